// File: rtl/cache_bus_pkg.sv
// Shared types and width helpers for the cache-to-memory bus arbiter.
package cache_bus_pkg;

  // Command payload fields are sized for the widest supported configuration.
  localparam int unsigned CMD_ADDR_W = 64;
  localparam int unsigned CMD_LINE_W = 1024;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_LOAD,
    RESP,
    WAIT_STORE
  } arb_state_e;

  typedef struct packed {
    logic                  store;
    logic [CMD_ADDR_W-1:0] addr;
    logic [CMD_LINE_W-1:0] data;
  } mem_cmd_t;

  function automatic int unsigned line_w(input int unsigned data_w, input int unsigned chunks_log);
    return data_w << chunks_log;
  endfunction

  function automatic int unsigned id_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cache_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_pick
  import cache_bus_pkg::*;
#(
  parameter  int unsigned N  = 4,
  localparam int unsigned IW = id_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] winner,
  output logic          any_valid
);

  logic [IW-1:0] idx;

  always_comb begin
    winner    = '0;
    any_valid = 1'b0;
    idx       = '0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = IW'((32'(ptr) + i) % N);
      if (!any_valid && req[idx]) begin
        winner    = idx;
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cache_bus_arbiter.sv
// Shares the single bus engine between cache requesters: picks one request
// round-robin, issues it as a full-line command and holds the grant until done.
module cache_bus_arbiter
  import cache_bus_pkg::*;
#(
  parameter  int unsigned CONNECTIONS = 4,
  parameter  int unsigned ADDR_WIDTH  = 64,
  parameter  int unsigned DATA_WIDTH  = 64,
  parameter  int unsigned CHUNKS_LOG  = 4,
  localparam int unsigned LINE_W      = line_w(DATA_WIDTH, CHUNKS_LOG),
  localparam int unsigned ID_W        = id_w(CONNECTIONS)
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [CONNECTIONS-1:0]                  req_valid,
  input  logic [CONNECTIONS-1:0]                  req_store,
  input  logic [CONNECTIONS-1:0][ADDR_WIDTH-1:0]  req_addr,
  input  logic [CONNECTIONS-1:0][LINE_W-1:0]      req_data,
  output logic [CONNECTIONS-1:0]                  req_ready,
  output logic [CONNECTIONS-1:0]                  resp_valid,
  input  logic [CONNECTIONS-1:0]                  resp_ready,
  output logic [LINE_W-1:0]                       resp_data,
  output logic [ID_W-1:0]                         grant_id,
  output logic                                    mem_cmd_valid,
  input  logic                                    mem_cmd_ready,
  output logic                                    mem_cmd_store,
  output logic [ADDR_WIDTH-1:0]                   mem_cmd_addr,
  output logic [LINE_W-1:0]                       mem_cmd_data,
  input  logic                                    mem_resp_valid,
  input  logic [LINE_W-1:0]                       mem_resp_data,
  output logic                                    mem_resp_ready,
  input  logic                                    mem_store_done
);

  arb_state_e        state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]   grant_id_q, grant_id_d;
  mem_cmd_t          cmd_q, cmd_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic [ID_W-1:0]   winner;
  logic              any_valid;

  rr_pick #(.N(CONNECTIONS)) u_pick (
    .req       (req_valid),
    .ptr       (rr_ptr_q),
    .winner    (winner),
    .any_valid (any_valid)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      cmd_q      <= '0;
      line_q     <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      cmd_q      <= cmd_d;
      line_q     <= line_d;
    end
  end

  // Next state, capture and output decode; one transaction in flight at most.
  always_comb begin
    state_d        = state_q;
    rr_ptr_d       = rr_ptr_q;
    grant_id_d     = grant_id_q;
    cmd_d          = cmd_q;
    line_d         = line_q;
    req_ready      = '0;
    resp_valid     = '0;
    mem_cmd_valid  = 1'b0;
    mem_resp_ready = 1'b0;

    unique case (state_q)
      IDLE: begin
        // No accept pulse while reset is held, since the capture would be discarded.
        if (any_valid && reset) begin
          req_ready[winner] = 1'b1;
          cmd_d.store       = req_store[winner];
          cmd_d.addr        = CMD_ADDR_W'(req_addr[winner]);
          cmd_d.data        = CMD_LINE_W'(req_data[winner]);
          grant_id_d        = winner;
          rr_ptr_d          = ID_W'((32'(winner) + 32'd1) % CONNECTIONS);
          state_d           = ISSUE;
        end
      end
      ISSUE: begin
        mem_cmd_valid = 1'b1;
        if (mem_cmd_ready) begin
          state_d = cmd_q.store ? WAIT_STORE : WAIT_LOAD;
        end
      end
      WAIT_LOAD: begin
        mem_resp_ready = 1'b1;
        if (mem_resp_valid) begin
          line_d  = mem_resp_data;
          state_d = RESP;
        end
      end
      RESP: begin
        resp_valid[grant_id_q] = 1'b1;
        if (resp_ready[grant_id_q]) begin
          state_d = IDLE;
        end
      end
      WAIT_STORE: begin
        if (mem_store_done) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign grant_id      = grant_id_q;
  assign resp_data     = line_q;
  assign mem_cmd_store = cmd_q.store;
  assign mem_cmd_addr  = ADDR_WIDTH'(cmd_q.addr);
  assign mem_cmd_data  = LINE_W'(cmd_q.data);

endmodule

// File: tb/tb_cache_bus_arbiter.sv
// Self-checking bench for cache_bus_arbiter: directed scenarios plus a random
// run against a transaction-level reference model.
module tb_cache_bus_arbiter;

  localparam int N  = 4;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam int CL = 4;
  localparam int LW = DW << CL;
  localparam int IW = 2;

  logic                    clk = 1'b0;
  logic                    reset;
  logic [N-1:0]            req_valid;
  logic [N-1:0]            req_store;
  logic [N-1:0][AW-1:0]    req_addr;
  logic [N-1:0][LW-1:0]    req_data;
  logic [N-1:0]            req_ready;
  logic [N-1:0]            resp_valid;
  logic [N-1:0]            resp_ready;
  logic [LW-1:0]           resp_data;
  logic [IW-1:0]           grant_id;
  logic                    mem_cmd_valid;
  logic                    mem_cmd_ready;
  logic                    mem_cmd_store;
  logic [AW-1:0]           mem_cmd_addr;
  logic [LW-1:0]           mem_cmd_data;
  logic                    mem_resp_valid;
  logic [LW-1:0]           mem_resp_data;
  logic                    mem_resp_ready;
  logic                    mem_store_done;

  int total = 0;
  int bad   = 0;

  cache_bus_arbiter #(
    .CONNECTIONS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CHUNKS_LOG(CL)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_store(req_store), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .grant_id(grant_id), .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready),
    .mem_cmd_store(mem_cmd_store), .mem_cmd_addr(mem_cmd_addr), .mem_cmd_data(mem_cmd_data),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .mem_resp_ready(mem_resp_ready), .mem_store_done(mem_store_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] l;
    for (int i = 0; i < LW / 32; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  // Requester closest to ptr going upward (modular distance), -1 if none.
  function automatic int pick(input logic [N-1:0] v, input int ptr);
    int best = -1;
    int bd   = N;
    for (int i = 0; i < N; i++) begin
      if (v[i] && ((i - ptr + N) % N) < bd) begin
        bd   = (i - ptr + N) % N;
        best = i;
      end
    end
    return best;
  endfunction

  function automatic logic [N-1:0] onehot(input int i);
    if (i < 0) return '0;
    return N'(1) << i;
  endfunction

  task automatic clear_inputs();
    req_valid      = '0;
    req_store      = '0;
    req_addr       = '0;
    req_data       = '0;
    resp_ready     = '0;
    mem_cmd_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    mem_store_done = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset     = 1'b0;
    req_valid = '1;
    tick();
    tick();
    #1;
    total++; if (req_ready !== '0) begin bad++; $display("FAIL reset_req_ready got=%b exp=0", req_ready); end
    total++; if (mem_cmd_valid !== 1'b0) begin bad++; $display("FAIL reset_cmd_valid got=%b exp=0", mem_cmd_valid); end
    total++; if (resp_valid !== '0 || mem_resp_ready !== 1'b0) begin bad++; $display("FAIL reset_resp got=%b/%b exp=0/0", resp_valid, mem_resp_ready); end
    total++; if (grant_id !== '0 || mem_cmd_addr !== '0 || resp_data !== '0) begin bad++; $display("FAIL reset_regs grant=%0d addr=%h data=%h exp=0", grant_id, mem_cmd_addr, resp_data[63:0]); end
    req_valid = '0;
    reset     = 1'b1;
    tick();
  endtask

  task automatic test_single_load();
    logic [LW-1:0] line;
    do_reset();
    line        = {16{64'hA5A5_A5A5_A5A5_A5A5}};
    req_valid   = 4'b0010;
    req_addr[1] = 64'h1000;
    #1;
    total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL load_accept got=%b exp=0010", req_ready); end
    tick();
    req_valid     = '0;
    req_addr[1]   = 64'hDEAD;
    mem_cmd_ready = 1'b1;
    #1;
    total++; if (mem_cmd_valid !== 1'b1 || mem_cmd_addr !== 64'h1000 || mem_cmd_store !== 1'b0) begin bad++; $display("FAIL load_cmd valid=%b addr=%h store=%b exp=1/1000/0", mem_cmd_valid, mem_cmd_addr, mem_cmd_store); end
    total++; if (grant_id !== 2'd1) begin bad++; $display("FAIL load_grant got=%0d exp=1", grant_id); end
    tick();
    mem_cmd_ready  = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_data  = line;
    #1;
    total++; if (mem_resp_ready !== 1'b1 || resp_valid !== '0) begin bad++; $display("FAIL load_wait rready=%b rvalid=%b exp=1/0000", mem_resp_ready, resp_valid); end
    tick();
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    resp_ready     = 4'b0010;
    #1;
    total++; if (resp_valid !== 4'b0010 || resp_data !== line) begin bad++; $display("FAIL load_resp valid=%b data=%h exp=0010/%h", resp_valid, resp_data[63:0], line[63:0]); end
    tick();
    resp_ready = '0;
    #1;
    total++; if (resp_valid !== '0) begin bad++; $display("FAIL load_resp_drop got=%b exp=0", resp_valid); end
  endtask

  // Zero-wait stores with fixed request patterns; accepts must land every 3 cycles.
  task automatic run_store_seq(input string name, input logic [N-1:0] pats[$], input int exp_ids[$]);
    for (int k = 0; k < pats.size(); k++) begin
      req_valid      = pats[k];
      mem_store_done = 1'b0;
      #1;
      total++; if (req_ready !== onehot(exp_ids[k])) begin bad++; $display("FAIL %s_accept k=%0d got=%b exp=%b", name, k, req_ready, onehot(exp_ids[k])); end
      tick();
      mem_cmd_ready = 1'b1;
      #1;
      total++; if (mem_cmd_valid !== 1'b1 || mem_cmd_addr !== req_addr[exp_ids[k]] || req_ready !== '0) begin bad++; $display("FAIL %s_cmd k=%0d valid=%b addr=%h rdy=%b exp=1/%h/0", name, k, mem_cmd_valid, mem_cmd_addr, req_ready, req_addr[exp_ids[k]]); end
      tick();
      mem_cmd_ready  = 1'b0;
      mem_store_done = 1'b1;
      #1;
      total++; if (req_ready !== '0) begin bad++; $display("FAIL %s_busy k=%0d got=%b exp=0", name, k, req_ready); end
      tick();
    end
    mem_store_done = 1'b0;
    req_valid      = '0;
  endtask

  task automatic test_round_robin();
    logic [N-1:0] pats[$];
    int           ids[$];
    do_reset();
    req_store = '1;
    for (int i = 0; i < N; i++) req_addr[i] = AW'(64'h100 + i * 64'h40);
    pats = '{4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111};
    ids  = '{0, 1, 2, 3, 0};
    run_store_seq("rr", pats, ids);
  endtask

  task automatic test_wrap();
    logic [N-1:0] pats[$];
    int           ids[$];
    do_reset();
    req_store = '1;
    for (int i = 0; i < N; i++) req_addr[i] = AW'(64'h2000 + i * 64'h80);
    pats = '{4'b0100, 4'b1000, 4'b0101, 4'b0101};
    ids  = '{2, 3, 0, 2};
    run_store_seq("wrap", pats, ids);
  endtask

  task automatic test_backpressure();
    logic [LW-1:0] sdata;
    logic [LW-1:0] line;
    do_reset();
    sdata       = rand_line();
    line        = rand_line();
    req_valid   = 4'b1000;
    req_addr[3] = 64'h3000;
    req_data[3] = sdata;
    #1;
    total++; if (req_ready !== 4'b1000) begin bad++; $display("FAIL bp_accept got=%b exp=1000", req_ready); end
    tick();
    req_valid = '0;
    for (int c = 0; c < 5; c++) begin
      req_addr[3] = {$urandom, $urandom};
      req_data[3] = rand_line();
      #1;
      total++; if (mem_cmd_valid !== 1'b1 || mem_cmd_addr !== 64'h3000 || mem_cmd_store !== 1'b0 || mem_cmd_data !== sdata) begin bad++; $display("FAIL bp_cmd_hold c=%0d valid=%b addr=%h data=%h exp=1/3000/%h", c, mem_cmd_valid, mem_cmd_addr, mem_cmd_data[63:0], sdata[63:0]); end
      tick();
    end
    mem_cmd_ready = 1'b1;
    tick();
    mem_cmd_ready  = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_data  = line;
    tick();
    mem_resp_valid = 1'b0;
    req_valid      = '1;
    for (int c = 0; c < 4; c++) begin
      #1;
      total++; if (resp_valid !== 4'b1000 || resp_data !== line || req_ready !== '0) begin bad++; $display("FAIL bp_resp_hold c=%0d valid=%b rdy=%b data=%h exp=1000/0000/%h", c, resp_valid, req_ready, resp_data[63:0], line[63:0]); end
      tick();
    end
    resp_ready = 4'b1000;
    tick();
    resp_ready = '0;
    #1;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL bp_next_accept got=%b exp=0001", req_ready); end
    tick();
    req_valid = '0;
  endtask

  task automatic test_stray();
    do_reset();
    mem_store_done = 1'b1;
    mem_resp_valid = 1'b1;
    mem_resp_data  = rand_line();
    #1;
    total++; if (mem_cmd_valid !== 1'b0 || mem_resp_ready !== 1'b0 || resp_valid !== '0 || req_ready !== '0) begin bad++; $display("FAIL stray_now cmd=%b rrdy=%b rv=%b rdy=%b exp=all0", mem_cmd_valid, mem_resp_ready, resp_valid, req_ready); end
    tick();
    mem_store_done = 1'b0;
    mem_resp_valid = 1'b0;
    #1;
    total++; if (mem_cmd_valid !== 1'b0 || resp_valid !== '0 || resp_data !== '0) begin bad++; $display("FAIL stray_after cmd=%b rv=%b data=%h exp=0/0/0", mem_cmd_valid, resp_valid, resp_data[63:0]); end
    req_valid = 4'b0100;
    #1;
    total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL stray_idle_accept got=%b exp=0100", req_ready); end
    tick();
    req_valid = '0;
  endtask

  task automatic test_reset_mid_load();
    do_reset();
    req_valid = '1;
    for (int i = 0; i < N; i++) req_addr[i] = AW'(64'h4000 + i);
    tick();
    req_valid     = '0;
    mem_cmd_ready = 1'b1;
    tick();
    mem_cmd_ready = 1'b0;
    req_valid     = '1;
    #1;
    total++; if (mem_resp_ready !== 1'b1) begin bad++; $display("FAIL rml_in_wait got=%b exp=1", mem_resp_ready); end
    reset = 1'b0;
    tick();
    #1;
    total++; if (mem_resp_ready !== 1'b0 || mem_cmd_valid !== 1'b0 || resp_valid !== '0 || req_ready !== '0 || grant_id !== '0) begin bad++; $display("FAIL rml_cleared rrdy=%b cmd=%b rv=%b rdy=%b grant=%0d exp=all0", mem_resp_ready, mem_cmd_valid, resp_valid, req_ready, grant_id); end
    reset = 1'b1;
    #1;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL rml_first_grant got=%b exp=0001", req_ready); end
    tick();
    req_valid = '0;
    #1;
    total++; if (mem_cmd_valid !== 1'b1 || mem_cmd_addr !== 64'h4000 || grant_id !== '0) begin bad++; $display("FAIL rml_first_cmd valid=%b addr=%h grant=%0d exp=1/4000/0", mem_cmd_valid, mem_cmd_addr, grant_id); end
  endtask

  // Random traffic: model tracks one outstanding transaction and its progress.
  task automatic test_random();
    int            m_ptr = 0;
    bit            outst = 0, cmd_taken = 0, got_line = 0, t_store = 0;
    int            t_id = 0, w, txns = 0, eng_delay = 0;
    bit            eng_active = 0, drv_done, drv_rv;
    logic [AW-1:0] t_addr = '0;
    logic [LW-1:0] t_data = '0, t_line = '0;
    logic [N-1:0]  exp_rv;
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      req_valid = N'($urandom);
      if ($urandom_range(0, 2) == 0) req_valid = '0;
      for (int i = 0; i < N; i++) begin
        req_store[i] = 1'($urandom);
        req_addr[i]  = {$urandom, $urandom};
        req_data[i]  = rand_line();
      end
      mem_cmd_ready = ($urandom_range(0, 2) != 0);
      resp_ready    = N'($urandom);
      drv_done = 0;
      drv_rv   = 0;
      if (eng_active) begin
        if (eng_delay > 0) eng_delay--;
        else begin
          eng_active = 0;
          if (t_store) drv_done = 1; else drv_rv = 1;
        end
      end else if (!(outst && cmd_taken) && $urandom_range(0, 5) == 0) begin
        drv_done = 1'($urandom);
        drv_rv   = 1'($urandom);
      end
      mem_store_done = drv_done;
      mem_resp_valid = drv_rv;
      mem_resp_data  = rand_line();
      #1;
      w = outst ? -1 : pick(req_valid, m_ptr);
      total++; if (req_ready !== onehot(w)) begin bad++; $display("FAIL rnd_req_ready cyc=%0d got=%b exp=%b", cyc, req_ready, onehot(w)); end
      total++; if (mem_cmd_valid !== (outst && !cmd_taken)) begin bad++; $display("FAIL rnd_cmd_valid cyc=%0d got=%b exp=%b", cyc, mem_cmd_valid, outst && !cmd_taken); end
      if (outst && !cmd_taken) begin
        total++; if (mem_cmd_store !== t_store || mem_cmd_addr !== t_addr || mem_cmd_data !== t_data) begin bad++; $display("FAIL rnd_cmd_fields cyc=%0d store=%b addr=%h data=%h exp=%b/%h/%h", cyc, mem_cmd_store, mem_cmd_addr, mem_cmd_data[63:0], t_store, t_addr, t_data[63:0]); end
      end
      total++; if (mem_resp_ready !== (outst && cmd_taken && !t_store && !got_line)) begin bad++; $display("FAIL rnd_mem_resp_ready cyc=%0d got=%b exp=%b", cyc, mem_resp_ready, outst && cmd_taken && !t_store && !got_line); end
      exp_rv = got_line ? onehot(t_id) : '0;
      total++; if (resp_valid !== exp_rv) begin bad++; $display("FAIL rnd_resp_valid cyc=%0d got=%b exp=%b", cyc, resp_valid, exp_rv); end
      if (got_line) begin
        total++; if (resp_data !== t_line) begin bad++; $display("FAIL rnd_resp_data cyc=%0d got=%h exp=%h", cyc, resp_data[63:0], t_line[63:0]); end
      end
      if (outst) begin
        total++; if (grant_id !== IW'(t_id)) begin bad++; $display("FAIL rnd_grant cyc=%0d got=%0d exp=%0d", cyc, grant_id, t_id); end
      end
      if (got_line) begin
        if (resp_ready[t_id]) begin outst = 0; got_line = 0; end
      end else if (outst && cmd_taken) begin
        if (t_store && drv_done) outst = 0;
        else if (!t_store && drv_rv) begin got_line = 1; t_line = mem_resp_data; end
      end
      if (outst && !cmd_taken && mem_cmd_ready) begin
        cmd_taken  = 1;
        eng_active = 1;
        eng_delay  = $urandom_range(0, 2);
      end
      if (w >= 0) begin
        outst     = 1;
        cmd_taken = 0;
        got_line  = 0;
        t_id      = w;
        t_store   = req_store[w];
        t_addr    = req_addr[w];
        t_data    = req_data[w];
        m_ptr     = (w + 1) % N;
        txns++;
      end
      tick();
    end
    total++; if (txns < 40) begin bad++; $display("FAIL rnd_txn_count got=%0d exp>=40", txns); end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    reset = 1'b0;
    test_reset();
    test_single_load();
    test_round_robin();
    test_wrap();
    test_backpressure();
    test_stray();
    test_reset_mid_load();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
